// File: rtl/aes_rcon_sched_if.sv
// Key-schedule word sequencer bus: load/advance controls in, per-word schedule fields out.
// Handshake: a word transfers on the rising edge where out_valid && adv; otherwise every output holds.
interface aes_rcon_sched_if #(
  parameter int OUT_W = 32,
  parameter int IDX_W = 6
);
  logic             kld;
  logic [1:0]       key_size;
  logic             adv;
  logic [OUT_W-1:0] out;
  logic             out_valid;
  logic             rcon_use;
  logic             sub_only;
  logic [IDX_W-1:0] word_idx;
  logic             last;
  logic             done;
  logic [1:0]       state_dbg;

  modport master (
    output kld, key_size, adv,
    input  out, out_valid, rcon_use, sub_only, word_idx, last, done, state_dbg
  );

  modport slave (
    input  kld, key_size, adv,
    output out, out_valid, rcon_use, sub_only, word_idx, last, done, state_dbg
  );
endinterface

// File: rtl/aes_rcon_sched.sv
// AES-128/192/256 key-schedule word sequencer with on-the-fly Rcon (xtime, no table).
// One expanded-key word per accepted advance; flags RotWord+SubWord+Rcon and SubWord-only words.
module aes_rcon_sched #(
  parameter logic [7:0] RC_POLY = 8'h1b,
  parameter logic [7:0] RC_INIT = 8'h01,
  parameter int         OUT_W   = 32,
  parameter int         IDX_W   = 6
) (
  input logic              clk,
  input logic              rst,
  aes_rcon_sched_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state;
  logic [3:0]       nk;
  logic [2:0]       phase;
  logic [7:0]       rcon;

  logic [3:0]       ld_nk;
  logic [IDX_W-1:0] idx_nx;
  logic [2:0]       phase_nx;
  logic [7:0]       rcon_nx;
  logic             xfer;

  function automatic logic [IDX_W-1:0] final_idx(input logic [3:0] n);
    case (n)
      4'd6:    final_idx = IDX_W'(51);
      4'd8:    final_idx = IDX_W'(59);
      default: final_idx = IDX_W'(43);
    endcase
  endfunction

  function automatic logic [OUT_W-1:0] pack_out(input logic [7:0] rc, input logic use_rc);
    pack_out = '0;
    if (use_rc) pack_out[OUT_W-1 -: 8] = rc;
  endfunction

  always_comb begin
    case (bus.key_size)
      2'd1:    ld_nk = 4'd6;
      2'd2:    ld_nk = 4'd8;
      default: ld_nk = 4'd4;
    endcase
    idx_nx   = bus.word_idx + {{(IDX_W-1){1'b0}}, 1'b1};
    phase_nx = ({1'b0, phase} == nk - 4'd1) ? 3'd0 : phase + 3'd1;
    // Rcon steps once per Nk words, on leaving the word that consumed it.
    rcon_nx  = (phase == 3'd0) ? ({rcon[6:0], 1'b0} ^ (rcon[7] ? RC_POLY : 8'h00)) : rcon;
    xfer     = (state == RUN) && bus.adv && bus.out_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      nk            <= 4'd4;
      phase         <= 3'd0;
      rcon          <= RC_INIT;
      bus.out       <= '0;
      bus.out_valid <= 1'b0;
      bus.rcon_use  <= 1'b0;
      bus.sub_only  <= 1'b0;
      bus.word_idx  <= '0;
      bus.last      <= 1'b0;
      bus.done      <= 1'b0;
    end else if (bus.kld) begin
      // Word Nk always starts a group and is never the final word.
      state         <= RUN;
      nk            <= ld_nk;
      phase         <= 3'd0;
      rcon          <= RC_INIT;
      bus.out       <= pack_out(RC_INIT, 1'b1);
      bus.out_valid <= 1'b1;
      bus.rcon_use  <= 1'b1;
      bus.sub_only  <= 1'b0;
      bus.word_idx  <= IDX_W'(ld_nk);
      bus.last      <= 1'b0;
      bus.done      <= 1'b0;
    end else if (xfer) begin
      if (bus.last) begin
        state         <= DONE;
        bus.out       <= '0;
        bus.out_valid <= 1'b0;
        bus.rcon_use  <= 1'b0;
        bus.sub_only  <= 1'b0;
        bus.last      <= 1'b0;
        bus.done      <= 1'b1;
      end else begin
        phase         <= phase_nx;
        rcon          <= rcon_nx;
        bus.word_idx  <= idx_nx;
        bus.out       <= pack_out(rcon_nx, phase_nx == 3'd0);
        bus.rcon_use  <= (phase_nx == 3'd0);
        bus.sub_only  <= (nk == 4'd8) && (phase_nx == 3'd4);
        bus.last      <= (idx_nx == final_idx(nk));
      end
    end
  end

  assign bus.state_dbg = state;

endmodule
